// File: rtl/mxu_pe_db_pkg.sv
// Shared MXU defaults: operand/accumulator widths and pipeline limits.
// Imported by every PE file so the array agrees on sizing.
package mxu_pe_db_pkg;

  localparam int MXU_DATA_W = 8;
  localparam int MXU_ACC_W  = 24;
  localparam int MXU_IDX_W  = 8;
  localparam int MXU_PIPE_MIN = 1;
  localparam int MXU_PIPE_MAX = 8;

endpackage

// File: rtl/mxu_pe_db_mac.sv
// Combinational multiply-accumulate for one MXU PE.
// Signed/unsigned product plus partial sum, with optional clamp.
module mxu_pe_db_mac
  import mxu_pe_db_pkg::*;
#(
  parameter int DATA_W   = MXU_DATA_W,
  parameter int ACC_W    = MXU_ACC_W,
  parameter int SATURATE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] w,
  input  logic [ACC_W-1:0]  psum,
  input  logic              signed_mode,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int PW  = 2 * DATA_W;
  localparam int PAD = ACC_W + 1 - PW;

  logic [PW-1:0] a_x;
  logic [PW-1:0] w_x;
  logic [PW-1:0] prod;
  logic [ACC_W:0] prod_x;
  logic [ACC_W:0] psum_x;
  logic [ACC_W:0] s;

  always_comb begin
    // low PW bits of the extended product are exact in both modes
    a_x = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
    w_x = {{DATA_W{signed_mode & w[DATA_W-1]}}, w};
    prod = a_x * w_x;
    prod_x = {{PAD{signed_mode & prod[PW-1]}}, prod};
    psum_x = {signed_mode & psum[ACC_W-1], psum};
    s = prod_x + psum_x;
    if (signed_mode) begin
      ovf = s[ACC_W] ^ s[ACC_W-1];
    end else begin
      ovf = s[ACC_W];
    end
    sum = s[ACC_W-1:0];
    if ((SATURATE != 0) && ovf) begin
      if (!signed_mode) begin
        sum = '1;
      end else if (s[ACC_W]) begin
        sum = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mxu_pe_db.sv
// Weight-stationary MXU PE with double-buffered weights,
// daisy-chained load/swap bus and a PIPE_DEPTH-deep MAC pipeline.
module mxu_pe_db
  import mxu_pe_db_pkg::*;
#(
  parameter int Y_INDEX    = 0,
  parameter int DATA_W     = MXU_DATA_W,
  parameter int ACC_W      = MXU_ACC_W,
  parameter int IDX_W      = MXU_IDX_W,
  parameter int PIPE_DEPTH = 3,
  parameter int SATURATE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signed_mode,
  input  logic              load_valid,
  input  logic [IDX_W-1:0]  load_target_y,
  input  logic [DATA_W-1:0] load_weight,
  input  logic              swap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] activation,
  input  logic [ACC_W-1:0]  partial_sum,
  output logic              load_valid_out,
  output logic [IDX_W-1:0]  load_target_y_out,
  output logic [DATA_W-1:0] load_weight_out,
  output logic              swap_out,
  output logic              act_valid_out,
  output logic [DATA_W-1:0] activation_out,
  output logic              out_valid,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic [DATA_W-1:0] active_weight
);

  logic              lv_q, lv_d;
  logic [IDX_W-1:0]  ly_q, ly_d;
  logic [DATA_W-1:0] lw_q, lw_d;
  logic              sw_q, sw_d;
  logic              av_q, av_d;
  logic [DATA_W-1:0] act_q, act_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;

  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] ovf_q, ovf_d;
  logic [ACC_W-1:0]      sum_q [PIPE_DEPTH];
  logic [ACC_W-1:0]      sum_d [PIPE_DEPTH];

  logic [ACC_W-1:0] mac_sum;
  logic             mac_ovf;
  logic             hit;

  mxu_pe_db_mac #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SATURATE(SATURATE)
  ) u_mac (
    .a          (activation),
    .w          (active_q),
    .psum       (partial_sum),
    .signed_mode(signed_mode),
    .sum        (mac_sum),
    .ovf        (mac_ovf)
  );

  assign hit = load_valid
    && (load_target_y == IDX_W'(Y_INDEX));

  always_comb begin
    lv_d  = load_valid;
    ly_d  = load_target_y;
    lw_d  = load_weight;
    sw_d  = swap;
    av_d  = in_valid;
    act_d = activation;
    shadow_d = hit ? load_weight : shadow_q;
    active_d = swap ? shadow_q : active_q;
    vld_d[0] = in_valid;
    sum_d[0] = in_valid ? mac_sum : sum_q[0];
    ovf_d[0] = in_valid ? mac_ovf : ovf_q[0];
    // data only advances with a valid beat so bubbles keep the last result
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      sum_d[i] = vld_q[i-1] ? sum_q[i-1] : sum_q[i];
      ovf_d[i] = vld_q[i-1] ? ovf_q[i-1] : ovf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv_q     <= 1'b0;
      ly_q     <= '0;
      lw_q     <= '0;
      sw_q     <= 1'b0;
      av_q     <= 1'b0;
      act_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      vld_q    <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sum_q[i] <= '0;
      end
    end else begin
      lv_q     <= lv_d;
      ly_q     <= ly_d;
      lw_q     <= lw_d;
      sw_q     <= sw_d;
      av_q     <= av_d;
      act_q    <= act_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        sum_q[i] <= sum_d[i];
      end
    end
  end

  assign load_valid_out    = lv_q;
  assign load_target_y_out = ly_q;
  assign load_weight_out   = lw_q;
  assign swap_out          = sw_q;
  assign act_valid_out     = av_q;
  assign activation_out    = act_q;
  assign out_valid         = vld_q[PIPE_DEPTH-1];
  assign result            = sum_q[PIPE_DEPTH-1];
  assign overflow          = ovf_q[PIPE_DEPTH-1];
  assign active_weight     = active_q;

endmodule

// File: tb/tb_mxu_pe_db.sv
// Bench for mxu_pe_db: constant vector table, arithmetic reference
// model over random traffic, and async reset mid-stream.
module tb_mxu_pe_db;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signed_mode = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_target_y = '0;
  logic [7:0]  load_weight = '0;
  logic        swap = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  activation = '0;
  logic [23:0] partial_sum = '0;

  logic        lvo [3];
  logic [7:0]  lto [3];
  logic [7:0]  lwo [3];
  logic        swo [3];
  logic        avo [3];
  logic [7:0]  aco [3];
  logic        ov  [3];
  logic [23:0] res [3];
  logic        ovf [3];
  logic [7:0]  aw  [3];

  int dep  [3] = '{3, 1, 3};
  int satf [3] = '{0, 0, 1};

  mxu_pe_db #(.Y_INDEX(2), .PIPE_DEPTH(3), .SATURATE(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .signed_mode(signed_mode),
    .load_valid(load_valid), .load_target_y(load_target_y),
    .load_weight(load_weight), .swap(swap), .in_valid(in_valid),
    .activation(activation), .partial_sum(partial_sum),
    .load_valid_out(lvo[0]), .load_target_y_out(lto[0]),
    .load_weight_out(lwo[0]), .swap_out(swo[0]),
    .act_valid_out(avo[0]), .activation_out(aco[0]),
    .out_valid(ov[0]), .result(res[0]), .overflow(ovf[0]),
    .active_weight(aw[0]));

  mxu_pe_db #(.Y_INDEX(2), .PIPE_DEPTH(1), .SATURATE(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .signed_mode(signed_mode),
    .load_valid(load_valid), .load_target_y(load_target_y),
    .load_weight(load_weight), .swap(swap), .in_valid(in_valid),
    .activation(activation), .partial_sum(partial_sum),
    .load_valid_out(lvo[1]), .load_target_y_out(lto[1]),
    .load_weight_out(lwo[1]), .swap_out(swo[1]),
    .act_valid_out(avo[1]), .activation_out(aco[1]),
    .out_valid(ov[1]), .result(res[1]), .overflow(ovf[1]),
    .active_weight(aw[1]));

  mxu_pe_db #(.Y_INDEX(2), .PIPE_DEPTH(3), .SATURATE(1)) u_s3 (
    .clk(clk), .rst_n(rst_n), .signed_mode(signed_mode),
    .load_valid(load_valid), .load_target_y(load_target_y),
    .load_weight(load_weight), .swap(swap), .in_valid(in_valid),
    .activation(activation), .partial_sum(partial_sum),
    .load_valid_out(lvo[2]), .load_target_y_out(lto[2]),
    .load_weight_out(lwo[2]), .swap_out(swo[2]),
    .act_valid_out(avo[2]), .activation_out(aco[2]),
    .out_valid(ov[2]), .result(res[2]), .overflow(ovf[2]),
    .active_weight(aw[2]));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  // reference arithmetic on plain integers
  task automatic ref_mac(input logic [7:0] a, input logic [7:0] w,
                         input logic [23:0] p, input logic sm,
                         output logic [23:0] rw, output logic [23:0] rs,
                         output logic o);
    longint av, wv, pv, s, lo, hi;
    av = longint'(a);
    wv = longint'(w);
    pv = longint'(p);
    if (sm) begin
      if (a[7]) av -= 256;
      if (w[7]) wv -= 256;
      if (p[23]) pv -= 64'sd16777216;
      lo = -64'sd8388608;
      hi = 64'sd8388607;
    end else begin
      lo = 0;
      hi = 64'sd16777215;
    end
    s = av * wv + pv;
    o = (s < lo) || (s > hi);
    rw = s[23:0];
    if (s > hi) rs = hi[23:0];
    else if (s < lo) rs = lo[23:0];
    else rs = s[23:0];
  endtask

  logic        bv  [2048];
  logic [23:0] brw [2048];
  logic [23:0] brs [2048];
  logic        bo  [2048];
  int          e = 0;
  int          rst_edge = 0;
  logic [7:0]  shadow_m = '0;
  logic [7:0]  active_m = '0;
  logic [23:0] hold_r [3] = '{24'd0, 24'd0, 24'd0};
  logic        hold_o [3] = '{1'b0, 1'b0, 1'b0};

  task automatic step();
    logic        p_lv, p_sw, p_iv, p_rst;
    logic [7:0]  p_ly, p_lw, p_act;
    int          k;
    logic        ev;
    p_lv = load_valid; p_ly = load_target_y; p_lw = load_weight;
    p_sw = swap; p_iv = in_valid; p_act = activation; p_rst = rst_n;
    e++;
    bv[e] = in_valid & rst_n;
    ref_mac(activation, active_m, partial_sum, signed_mode,
            brw[e], brs[e], bo[e]);
    if (rst_n) begin
      if (swap) active_m = shadow_m;
      if (load_valid && load_target_y == 8'd2) shadow_m = load_weight;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("lv_out", {31'd0, lvo[d]}, {31'd0, p_lv & p_rst});
      chk("ly_out", {24'd0, lto[d]}, {24'd0, p_rst ? p_ly : 8'd0});
      chk("lw_out", {24'd0, lwo[d]}, {24'd0, p_rst ? p_lw : 8'd0});
      chk("swap_out", {31'd0, swo[d]}, {31'd0, p_sw & p_rst});
      chk("av_out", {31'd0, avo[d]}, {31'd0, p_iv & p_rst});
      chk("act_out", {24'd0, aco[d]}, {24'd0, p_rst ? p_act : 8'd0});
      chk("active_w", {24'd0, aw[d]}, {24'd0, active_m});
      k = e - dep[d] + 1;
      ev = (k >= 1) && (k > rst_edge) && bv[k];
      if (ev) begin
        hold_r[d] = (satf[d] != 0) ? brs[k] : brw[k];
        hold_o[d] = bo[k];
      end
      chk("out_valid", {31'd0, ov[d]}, {31'd0, ev});
      chk("result", {8'd0, res[d]}, {8'd0, hold_r[d]});
      chk("overflow", {31'd0, ovf[d]}, {31'd0, hold_o[d]});
    end
  endtask

  task automatic drive(input logic lv, input logic [7:0] ty,
                       input logic [7:0] lw, input logic sw,
                       input logic iv, input logic [7:0] a,
                       input logic [23:0] p, input logic sm);
    load_valid = lv; load_target_y = ty; load_weight = lw;
    swap = sw; in_valid = iv; activation = a;
    partial_sum = p; signed_mode = sm;
  endtask

  typedef struct {
    logic lv; logic [7:0] ty; logic [7:0] lw; logic sw;
    logic iv; logic [7:0] act; logic [23:0] ps; logic sm;
    logic ev; logic [23:0] er; logic eo; logic [7:0] eaw;
    logic c3; logic [23:0] e3r; logic e3o;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // expected values below are for the depth-1 wrapping PE
    tbl[0]  = '{1, 2, 5,   0, 0, 0,   0,        0, 0, 0,        0, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 0, 0,   1, 0, 0,   0,        0, 0, 0,        0, 8'h05, 0, 0, 0};
    tbl[2]  = '{1, 2, 9,   0, 0, 0,   0,        0, 0, 0,        0, 8'h05, 0, 0, 0};
    tbl[3]  = '{0, 0, 0,   0, 1, 3,   10,       0, 1, 25,       0, 8'h05, 0, 0, 0};
    tbl[4]  = '{0, 0, 0,   1, 1, 3,   10,       0, 1, 25,       0, 8'h09, 0, 0, 0};
    tbl[5]  = '{0, 0, 0,   0, 1, 3,   10,       0, 1, 37,       0, 8'h09, 0, 0, 0};
    tbl[6]  = '{1, 3, 100, 0, 0, 0,   0,        0, 0, 37,       0, 8'h09, 0, 0, 0};
    tbl[7]  = '{0, 0, 0,   1, 0, 0,   0,        0, 0, 37,       0, 8'h09, 0, 0, 0};
    tbl[8]  = '{1, 2, 4,   0, 0, 0,   0,        0, 0, 37,       0, 8'h09, 0, 0, 0};
    tbl[9]  = '{1, 2, 7,   1, 1, 1,   0,        0, 1, 9,        0, 8'h04, 0, 0, 0};
    tbl[10] = '{0, 0, 0,   0, 1, 1,   0,        0, 1, 4,        0, 8'h04, 0, 0, 0};
    tbl[11] = '{0, 0, 0,   1, 1, 1,   0,        0, 1, 4,        0, 8'h07, 0, 0, 0};
    tbl[12] = '{0, 0, 0,   0, 1, 1,   0,        0, 1, 7,        0, 8'h07, 0, 0, 0};
    tbl[13] = '{1, 2, 128, 0, 0, 0,   0,        0, 0, 7,        0, 8'h07, 0, 0, 0};
    tbl[14] = '{0, 0, 0,   1, 0, 0,   0,        0, 0, 7,        0, 8'h80, 0, 0, 0};
    tbl[15] = '{0, 0, 0,   0, 1, 128, 24'h7FFFFF, 1, 1, 24'h803FFF, 1, 8'h80, 0, 0, 0};
    tbl[16] = '{0, 0, 0,   0, 0, 0,   0,        0, 0, 24'h803FFF, 1, 8'h80, 0, 0, 0};
    tbl[17] = '{0, 0, 0,   0, 0, 0,   0,        0, 0, 24'h803FFF, 1, 8'h80, 1, 24'h7FFFFF, 1};
    tbl[18] = '{0, 0, 0,   0, 1, 255, 24'hFFFFFF, 0, 1, 24'h007F7F, 1, 8'h80, 0, 0, 0};
    tbl[19] = '{0, 0, 0,   0, 1, 2,   0,        1, 1, 24'hFFFF00, 0, 8'h80, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_valid", {31'd0, ov[d]}, 32'd0);
      chk("rst_result", {8'd0, res[d]}, 32'd0);
      chk("rst_weight", {24'd0, aw[d]}, 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].lv, tbl[i].ty, tbl[i].lw, tbl[i].sw,
            tbl[i].iv, tbl[i].act, tbl[i].ps, tbl[i].sm);
      step();
      chk($sformatf("tbl%0d_valid", i), {31'd0, ov[1]}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d_result", i), {8'd0, res[1]}, {8'd0, tbl[i].er});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf[1]}, {31'd0, tbl[i].eo});
      chk($sformatf("tbl%0d_aw", i), {24'd0, aw[1]}, {24'd0, tbl[i].eaw});
      if (tbl[i].c3) begin
        chk("sat_valid", {31'd0, ov[2]}, 32'd1);
        chk("sat_result", {8'd0, res[2]}, {8'd0, tbl[i].e3r});
        chk("sat_ovf", {31'd0, ovf[2]}, {31'd0, tbl[i].e3o});
      end
    end

    // bubble pattern 1,1,0,1,1,1 then drain
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 0, (i < 6) && (i != 2), 8'($urandom),
            24'($urandom), 1'($urandom));
      step();
    end

    for (int i = 0; i < 400; i++) begin
      logic [23:0] p;
      p = 24'($urandom);
      if ($urandom_range(0, 7) == 0) p = {p[23], {23{~p[23]}}};
      drive($urandom_range(0, 2) == 0, 8'($urandom_range(0, 3)),
            8'($urandom), $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), p,
            1'($urandom));
      step();
    end

    // async reset with beats in flight
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 8'($urandom), 24'($urandom), 0);
      step();
    end
    #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("arst_valid", {31'd0, ov[d]}, 32'd0);
      chk("arst_result", {8'd0, res[d]}, 32'd0);
      chk("arst_ovf", {31'd0, ovf[d]}, 32'd0);
      chk("arst_lv", {31'd0, avo[d]}, 32'd0);
      chk("arst_weight", {24'd0, aw[d]}, 32'd0);
    end
    shadow_m = '0;
    active_m = '0;
    rst_edge = e;
    for (int d = 0; d < 3; d++) begin
      hold_r[d] = '0;
      hold_o[d] = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 8'd77, 24'h001234, 0);
    step();
    chk("post_rst_result", {8'd0, res[1]}, 32'h1234);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
